// File: rtl/jtbubl_snd_post_pkg.sv
// jtbubl_snd_post_pkg: shared FSM states, gain and saturation constants for the
// audio post-processing stage.
package jtbubl_snd_post_pkg;

   typedef enum logic [2:0] {IDLE, DIFF, MUL1, ACC, MUL2, OUT} state_t;

   localparam logic [8:0]  GAIN_UNITY = 9'd256;
   localparam logic [15:0] SAT_MAX    = 16'h7FFF;
   localparam logic [15:0] SAT_MIN    = 16'h8000;

   // {clip, value}: clamps an 18-bit signed sum to the 16-bit signed range
   function automatic logic [16:0] sat16(input logic signed [17:0] s);
      return (s > 18'sd32767)  ? {1'b1, SAT_MAX} :
             (s < -18'sd32768) ? {1'b1, SAT_MIN} : {1'b0, s[15:0]};
   endfunction

endpackage

// File: rtl/jtbubl_sermul.sv
// jtbubl_sermul: serial shift-add multiplier, 18-bit signed a times 9-bit
// unsigned b over nb clocks; p is the product arithmetically shifted right by 8.
module jtbubl_sermul (
   input  logic        clk,
   input  logic        rstn,
   input  logic        start,
   input  logic [17:0] a,
   input  logic [8:0]  b,
   input  logic [3:0]  nb,
   output logic        done,
   output logic [17:0] p
);

   logic [26:0] acc_q, acc_d, a_q, a_d;
   logic [8:0]  b_q, b_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        run;

   assign run  = cnt_q != 4'd0;
   assign done = cnt_q == 4'd1;
   assign p    = acc_q[25:8];

   always_comb begin
      acc_d = start ? 27'd0 : (run && b_q[0]) ? acc_q + a_q : acc_q;
      a_d   = start ? {{9{a[17]}}, a} : run ? a_q << 1 : a_q;
      b_d   = start ? b : run ? b_q >> 1 : b_q;
      cnt_d = start ? nb : run ? cnt_q - 4'd1 : cnt_q;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         acc_q <= '0;
         a_q   <= '0;
         b_q   <= '0;
         cnt_q <= '0;
      end else begin
         acc_q <= acc_d;
         a_q   <= a_d;
         b_q   <= b_d;
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/jtbubl_snd_post.sv
// jtbubl_snd_post: RC-style one-pole low-pass, 16-bit saturation and click-free
// gain ramp on the mixed sound sample, with held peak and sticky overrun flags.
module jtbubl_snd_post
   import jtbubl_snd_post_pkg::*;
#(
   parameter logic [15:0] PEAK_TH   = 16'h7F00,
   parameter logic [15:0] PEAK_HOLD = 16'd4800,
   parameter logic [8:0]  RAMP_STEP = 9'd1
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic [15:0] din,
   input  logic        din_stb,
   input  logic        enable,
   input  logic [7:0]  lpf_k,
   output logic [15:0] dout,
   output logic        dout_stb,
   output logic        peak,
   output logic        overrun,
   input  logic        ovr_clr
);

   state_t      st_q, st_d;
   logic [15:0] x_q, x_d, y_q, y_d, dout_q, dout_d, pcnt_q, pcnt_d;
   logic [8:0]  gain_q, gain_d;
   logic        kz_q, kz_d, clip_q, clip_d, stb_q, stb_d, ovr_q, ovr_d;

   logic        mul_start, mul_done;
   logic [17:0] mul_a, mul_p, sum;
   logic [8:0]  mul_b, gain_inc, gain_dec;
   logic [3:0]  mul_nb;
   logic [16:0] diff, sat, ye, ay;
   logic [15:0] y_acc;
   logic [9:0]  gsum;
   logic        drop, trig;

   assign diff  = {x_q[15], x_q} - {y_q[15], y_q};
   assign sum   = {{2{y_q[15]}}, y_q} + mul_p;
   assign sat   = sat16(sum);
   assign y_acc = kz_q ? x_q : sat[15:0];

   // DIFF launches x-y times k; ACC launches the freshly filtered y times gain
   assign mul_start = (st_q == DIFF) || (st_q == ACC);
   assign mul_a     = (st_q == DIFF) ? {diff[16], diff} : {{2{y_acc[15]}}, y_acc};
   assign mul_b     = (st_q == DIFF) ? {1'b0, lpf_k} : gain_q;
   assign mul_nb    = (st_q == DIFF) ? 4'd8 : 4'd9;

   assign gsum     = {1'b0, gain_q} + {1'b0, RAMP_STEP};
   assign gain_inc = (gsum > {1'b0, GAIN_UNITY}) ? GAIN_UNITY : gsum[8:0];
   assign gain_dec = (gain_q > RAMP_STEP) ? gain_q - RAMP_STEP : 9'd0;

   // 17-bit magnitude so that -32768 is seen as 32768
   assign ye   = {y_q[15], y_q};
   assign ay   = y_q[15] ? 17'd0 - ye : ye;
   assign trig = clip_q || (ay >= {1'b0, PEAK_TH});
   assign drop = din_stb && (st_q != IDLE);

   jtbubl_sermul u_mul (
      .clk   (clk),
      .rstn  (rstn),
      .start (mul_start),
      .a     (mul_a),
      .b     (mul_b),
      .nb    (mul_nb),
      .done  (mul_done),
      .p     (mul_p)
   );

   always_comb begin
      st_d   = st_q;
      x_d    = x_q;
      y_d    = y_q;
      kz_d   = kz_q;
      clip_d = clip_q;
      dout_d = dout_q;
      gain_d = gain_q;
      pcnt_d = pcnt_q;
      stb_d  = st_q == OUT;
      ovr_d  = drop ? 1'b1 : ovr_clr ? 1'b0 : ovr_q;
      case (st_q)
         IDLE: begin
            x_d  = din_stb ? din : x_q;
            st_d = din_stb ? DIFF : IDLE;
         end
         DIFF: begin
            kz_d = lpf_k == 8'd0;
            st_d = MUL1;
         end
         MUL1: st_d = mul_done ? ACC : MUL1;
         ACC: begin
            y_d    = y_acc;
            clip_d = !kz_q && sat[16];
            st_d   = MUL2;
         end
         MUL2: st_d = mul_done ? OUT : MUL2;
         OUT: begin
            dout_d = mul_p[15:0];
            gain_d = enable ? gain_inc : gain_dec;
            pcnt_d = trig ? PEAK_HOLD : (pcnt_q != 16'd0) ? pcnt_q - 16'd1 : 16'd0;
            st_d   = IDLE;
         end
         default: st_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         st_q   <= IDLE;
         x_q    <= '0;
         y_q    <= '0;
         kz_q   <= 1'b0;
         clip_q <= 1'b0;
         dout_q <= '0;
         gain_q <= '0;
         pcnt_q <= '0;
         stb_q  <= 1'b0;
         ovr_q  <= 1'b0;
      end else begin
         st_q   <= st_d;
         x_q    <= x_d;
         y_q    <= y_d;
         kz_q   <= kz_d;
         clip_q <= clip_d;
         dout_q <= dout_d;
         gain_q <= gain_d;
         pcnt_q <= pcnt_d;
         stb_q  <= stb_d;
         ovr_q  <= ovr_d;
      end
   end

   assign dout     = dout_q;
   assign dout_stb = stb_q;
   assign peak     = pcnt_q != 16'd0;
   assign overrun  = ovr_q;

endmodule

// File: tb/tb_jtbubl_snd_post.sv
// tb_jtbubl_snd_post: directed vectors and hand-written sequences for the
// audio post-processing stage, built with a short peak hold of 4 samples.
module tb_jtbubl_snd_post;

   logic        clk, rstn, din_stb, enable, ovr_clr;
   logic [15:0] din;
   logic [7:0]  lpf_k;
   logic [15:0] dout;
   logic        dout_stb, peak, overrun;

   int n_cmp = 0;
   int n_err = 0;

   typedef struct packed {
      logic [15:0] din;
      logic [7:0]  k;
      logic        en;
      logic [15:0] q;
      logic        pk;
   } vec_t;

   vec_t tv [38];

   jtbubl_snd_post #(.PEAK_HOLD(16'd4)) dut (
      .clk      (clk),
      .rstn     (rstn),
      .din      (din),
      .din_stb  (din_stb),
      .enable   (enable),
      .lpf_k    (lpf_k),
      .dout     (dout),
      .dout_stb (dout_stb),
      .peak     (peak),
      .overrun  (overrun),
      .ovr_clr  (ovr_clr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic send(input logic [15:0] v, output int lat, output logic [15:0] q, output logic pk);
      bit got = 0;
      @(negedge clk);
      din = v;
      din_stb = 1'b1;
      @(posedge clk);
      #1 din_stb = 1'b0;
      lat = 0;
      while (!got && lat < 40) begin
         @(posedge clk);
         lat++;
         #1;
         if (dout_stb) got = 1;
      end
      if (!got) begin
         n_cmp++;
         n_err++;
         $display("FAIL send_timeout: got no dout_stb expected one within 40 clk");
      end
      q = dout;
      pk = peak;
      repeat (2) @(posedge clk);
   endtask

   task automatic count_stb(input int ncyc, output int cnt, output logic [15:0] q);
      cnt = 0;
      q = '0;
      repeat (ncyc) begin
         @(posedge clk);
         #1;
         if (dout_stb) begin
            cnt++;
            q = dout;
         end
      end
   endtask

   task automatic pulse_stb(input logic [15:0] v);
      @(negedge clk);
      din = v;
      din_stb = 1'b1;
      @(posedge clk);
      #1 din_stb = 1'b0;
   endtask

   initial begin
      int lat, cnt;
      logic [15:0] q;
      logic pk;
      tv[0]  = '{16'h0000, 8'h00, 1'b1, 16'h0000, 1'b0};
      tv[1]  = '{16'h1000, 8'h80, 1'b1, 16'h0800, 1'b0};
      tv[2]  = '{16'h1000, 8'h80, 1'b1, 16'h0C00, 1'b0};
      tv[3]  = '{16'h1000, 8'h80, 1'b1, 16'h0E00, 1'b0};
      tv[4]  = '{16'h1000, 8'h80, 1'b1, 16'h0F00, 1'b0};
      tv[5]  = '{16'h1000, 8'h80, 1'b1, 16'h0F80, 1'b0};
      tv[6]  = '{16'h1000, 8'h80, 1'b1, 16'h0FC0, 1'b0};
      tv[7]  = '{16'h1000, 8'h80, 1'b1, 16'h0FE0, 1'b0};
      tv[8]  = '{16'h1000, 8'h80, 1'b1, 16'h0FF0, 1'b0};
      tv[9]  = '{16'h1000, 8'h80, 1'b1, 16'h0FF8, 1'b0};
      tv[10] = '{16'h1000, 8'h80, 1'b1, 16'h0FFC, 1'b0};
      tv[11] = '{16'h1000, 8'h80, 1'b1, 16'h0FFE, 1'b0};
      tv[12] = '{16'h1000, 8'h80, 1'b1, 16'h0FFF, 1'b0};
      tv[13] = '{16'h1000, 8'h80, 1'b1, 16'h0FFF, 1'b0};
      tv[14] = '{16'hFF9C, 8'h00, 1'b1, 16'hFF9C, 1'b0};
      tv[15] = '{16'h0100, 8'hFF, 1'b1, 16'h00FE, 1'b0};
      tv[16] = '{16'hFF00, 8'h40, 1'b1, 16'h007E, 1'b0};
      tv[17] = '{16'h4000, 8'h00, 1'b0, 16'h4000, 1'b0};
      tv[18] = '{16'h4000, 8'h00, 1'b0, 16'h3FC0, 1'b0};
      tv[19] = '{16'h4000, 8'h00, 1'b0, 16'h3F80, 1'b0};
      tv[20] = '{16'hC000, 8'h00, 1'b1, 16'hC0C0, 1'b0};
      tv[21] = '{16'h0000, 8'h00, 1'b1, 16'h0000, 1'b0};
      tv[22] = '{16'h0000, 8'h00, 1'b1, 16'h0000, 1'b0};
      tv[23] = '{16'h7000, 8'h00, 1'b1, 16'h7000, 1'b0};
      tv[24] = '{16'h7FFF, 8'h00, 1'b1, 16'h7FFF, 1'b1};
      tv[25] = '{16'h7FFF, 8'h00, 1'b1, 16'h7FFF, 1'b1};
      tv[26] = '{16'h0000, 8'h00, 1'b1, 16'h0000, 1'b1};
      tv[27] = '{16'h0000, 8'h00, 1'b1, 16'h0000, 1'b1};
      tv[28] = '{16'h0000, 8'h00, 1'b1, 16'h0000, 1'b1};
      tv[29] = '{16'h0000, 8'h00, 1'b1, 16'h0000, 1'b0};
      tv[30] = '{16'h8000, 8'h00, 1'b1, 16'h8000, 1'b1};
      tv[31] = '{16'h7EFF, 8'h00, 1'b1, 16'h7EFF, 1'b1};
      tv[32] = '{16'h7F00, 8'h00, 1'b1, 16'h7F00, 1'b1};
      tv[33] = '{16'h8100, 8'h00, 1'b1, 16'h8100, 1'b1};
      tv[34] = '{16'h0000, 8'h00, 1'b1, 16'h0000, 1'b1};
      tv[35] = '{16'h0000, 8'h00, 1'b1, 16'h0000, 1'b1};
      tv[36] = '{16'h0000, 8'h00, 1'b1, 16'h0000, 1'b1};
      tv[37] = '{16'h0000, 8'h00, 1'b1, 16'h0000, 1'b0};

      rstn = 1'b0;
      din = '0;
      din_stb = 1'b0;
      enable = 1'b1;
      lpf_k = 8'h00;
      ovr_clr = 1'b0;
      #12;
      check("rst_dout", dout, 16'h0000);
      check("rst_stb", dout_stb, 1'b0);
      check("rst_peak", peak, 1'b0);
      check("rst_ovr", overrun, 1'b0);
      @(negedge clk);
      rstn = 1'b1;

      // soft start: gain climbs one step per sample from 0 to unity
      for (int i = 1; i <= 260; i++) begin
         send(16'h4000, lat, q, pk);
         check($sformatf("ramp_%0d", i), q, 16'h0040 * ((i > 257) ? 256 : i - 1));
      end

      send(16'hFB2E, lat, q, pk);
      check("lat_cycles", lat, 20);
      check("lat_dout", q, 16'hFB2E);
      count_stb(40, cnt, q);
      check("lat_extra_stb", cnt, 0);

      for (int i = 0; i < 38; i++) begin
         enable = tv[i].en;
         lpf_k = tv[i].k;
         send(tv[i].din, lat, q, pk);
         check($sformatf("vec%0d_dout", i), q, tv[i].q);
         check($sformatf("vec%0d_peak", i), pk, tv[i].pk);
      end

      enable = 1'b1;
      lpf_k = 8'h00;
      check("ovr_idle", overrun, 1'b0);
      pulse_stb(16'h0100);
      repeat (9) @(posedge clk);
      pulse_stb(16'h2000);
      count_stb(40, cnt, q);
      check("ovr_stb_count", cnt, 1);
      check("ovr_dout", q, 16'h0100);
      check("ovr_set", overrun, 1'b1);
      repeat (5) @(posedge clk);
      check("ovr_sticky", overrun, 1'b1);

      pulse_stb(16'h0200);
      repeat (3) @(posedge clk);
      @(negedge clk);
      din_stb = 1'b1;
      ovr_clr = 1'b1;
      @(posedge clk);
      #1 din_stb = 1'b0;
      ovr_clr = 1'b0;
      check("ovr_set_wins", overrun, 1'b1);
      count_stb(40, cnt, q);
      check("ovr2_stb_count", cnt, 1);
      check("ovr2_dout", q, 16'h0200);
      @(negedge clk);
      ovr_clr = 1'b1;
      @(posedge clk);
      #1 ovr_clr = 1'b0;
      check("ovr_clear", overrun, 1'b0);

      // second strobe lands in the OUT cycle of the first sample
      pulse_stb(16'h0300);
      repeat (19) @(posedge clk);
      pulse_stb(16'h0400);
      check("out_drop_stb", dout_stb, 1'b1);
      check("out_drop_dout", dout, 16'h0300);
      check("out_drop_ovr", overrun, 1'b1);
      count_stb(40, cnt, q);
      check("out_drop_count", cnt, 0);
      @(negedge clk);
      ovr_clr = 1'b1;
      @(posedge clk);
      #1 ovr_clr = 1'b0;

      send(16'h7FFF, lat, q, pk);
      check("pre_rst_peak", pk, 1'b1);
      pulse_stb(16'h7FFF);
      repeat (4) @(posedge clk);
      pulse_stb(16'h1111);
      check("pre_rst_ovr", overrun, 1'b1);
      repeat (8) @(posedge clk);
      #2 rstn = 1'b0;
      #1;
      check("midrst_dout", dout, 16'h0000);
      check("midrst_stb", dout_stb, 1'b0);
      check("midrst_peak", peak, 1'b0);
      check("midrst_ovr", overrun, 1'b0);
      repeat (3) @(negedge clk);
      rstn = 1'b1;
      count_stb(40, cnt, q);
      check("midrst_no_stb", cnt, 0);
      lpf_k = 8'h80;
      send(16'h4000, lat, q, pk);
      check("post_rst_s1", q, 16'h0000);
      send(16'h4000, lat, q, pk);
      check("post_rst_s2", q, 16'h0030);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
